// File: rtl/trig_record_reader.sv
// trig_record_reader: reads one spill's trigger words back from the recorder RAM
// and frames them as a valid/ready stream: header, records, trailer.
module trig_record_reader #(
  parameter int ADDR_W  = 16,
  parameter int RAM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       ntrig,
  input  logic [1:0]        spill,
  output logic [ADDR_W-1:0] raddr,
  output logic              ren,
  input  logic [31:0]       rdata,
  output logic [31:0]       dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done,
  output logic              start_missed,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, HDR, READ, TRL} state_t;

  // Skid FIFO holds every word that can be in flight, so nothing returning is lost.
  localparam int DEPTH = RAM_LAT + 1;
  localparam int CW    = 4;
  localparam int PW    = 3;
  localparam logic [32:0]     MAX_RECS = 33'd1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [PW-1:0]   PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);

  state_t state, state_next;

  logic [ADDR_W:0]  cnt, sent, issued, cnt_in, sent_inc;
  logic [1:0]       spill_q;
  logic             ovf_in, accept, pop, push, issue, can_issue, trl_xfer;
  logic [RAM_LAT-1:0] pipe;
  logic [31:0]      fifo_mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    occ, inflight, pending;
  logic [16:0]      cnt_field, sent_field;
  logic [31:0]      header, trailer;

  assign ovf_in     = {1'b0, ntrig} > MAX_RECS;
  assign cnt_in     = ovf_in ? MAX_RECS[ADDR_W:0] : ntrig[ADDR_W:0];
  assign accept     = start && (state == IDLE);
  assign push       = pipe[RAM_LAT-1];
  assign pop        = (state == READ) && (occ != '0) && dout_ready;
  assign trl_xfer   = (state == TRL) && dout_ready;
  assign sent_inc   = sent + CNT_ONE;
  assign cnt_field  = 17'(cnt);
  assign sent_field = 17'(sent);
  assign header     = {4'hA, 1'b0, ovf, spill_q, 7'b0, cnt_field};
  assign trailer    = {4'hE, 11'b0, sent_field};
  assign busy       = (state != IDLE);
  assign ren        = issue;
  assign raddr      = issued[ADDR_W-1:0];

  // Count reads still travelling through the RAM, including the one landing this cycle.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RAM_LAT; i++) begin
      inflight = inflight + {{(CW-1){1'b0}}, pipe[i]};
    end
  end

  // Credit check: a word popped this cycle frees its slot immediately, keeping 1 word/cycle.
  always_comb begin
    pending   = occ + inflight - {{(CW-1){1'b0}}, pop};
    can_issue = (issued < cnt) && (pending < DEPTH_C);
  end

  // Next-state and stream outputs; the first read goes out on the header handshake.
  always_comb begin
    state_next = state;
    dout       = '0;
    dout_valid = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = HDR;
      end
      HDR: begin
        dout       = header;
        dout_valid = 1'b1;
        if (dout_ready) begin
          issue      = can_issue;
          state_next = (cnt != '0) ? READ : TRL;
        end
      end
      READ: begin
        if (occ != '0) begin
          dout       = fifo_mem[rd_ptr];
          dout_valid = 1'b1;
        end
        issue = can_issue;
        if (pop && (sent_inc == cnt)) state_next = TRL;
      end
      TRL: begin
        dout       = trailer;
        dout_valid = 1'b1;
        if (dout_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus the per-spill latches and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      sent         <= '0;
      issued       <= '0;
      spill_q      <= '0;
      ovf          <= 1'b0;
      done         <= 1'b0;
      start_missed <= 1'b0;
    end else begin
      state <= state_next;
      done  <= trl_xfer;
      if (start && (state != IDLE)) start_missed <= 1'b1;
      if (accept) begin
        cnt     <= cnt_in;
        ovf     <= ovf_in;
        spill_q <= spill;
        sent    <= '0;
        issued  <= '0;
      end
      if (issue) issued <= issued + CNT_ONE;
      if (pop)   sent   <= sent_inc;
    end
  end

  // Shadow of the RAM read latency; clearing it on reset discards data still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= issue;
      for (int i = 1; i < RAM_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Skid FIFO pointers and occupancy, wrapping at the non-power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_ONE;
      occ <= occ + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

  // Skid FIFO storage; returning RAM words are captured as they land.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rdata;
  end

endmodule

// File: tb/tb_trig_record_reader.sv
// tb_trig_record_reader: drives three readers (RAM_LAT 1, 2, 4) in parallel from a shared
// RAM image and compares each one's accepted stream with the stream built from the rules.
module tb_trig_record_reader;

  localparam int NI   = 3;
  localparam int MAXW = 65540;

  logic        clk = 1'b0;
  logic        rst, start, dout_ready;
  logic [31:0] ntrig;
  logic [1:0]  spill;

  logic [15:0] raddr_a [NI];
  logic        ren_a [NI];
  logic [31:0] rdata_a [NI];
  logic [31:0] dout_a [NI];
  logic        dout_valid_a [NI];
  logic        busy_a [NI];
  logic        done_a [NI];
  logic        start_missed_a [NI];
  logic        ovf_a [NI];

  logic [31:0] mem [65536];
  logic [31:0] rd_pipe [NI][4];
  logic [31:0] got [NI][MAXW];
  int          got_n [NI];
  int          done_n [NI];
  int          ren_n [NI];
  int          addr_err [NI];
  int          stall_err [NI];
  logic [15:0] last_raddr [NI];
  logic        prev_stall [NI];
  logic [31:0] prev_dout [NI];
  bit          mon_en = 1'b0;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];
  int          exp_cnt;
  bit          exp_ovf;

  always #5 clk = ~clk;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
  endfunction

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      trig_record_reader #(.ADDR_W(16), .RAM_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst), .start(start), .ntrig(ntrig), .spill(spill),
        .raddr(raddr_a[g]), .ren(ren_a[g]), .rdata(rdata_a[g]),
        .dout(dout_a[g]), .dout_valid(dout_valid_a[g]), .dout_ready(dout_ready),
        .busy(busy_a[g]), .done(done_a[g]), .start_missed(start_missed_a[g]), .ovf(ovf_a[g])
      );
      assign rdata_a[g] = rd_pipe[g][LAT-1];
    end
  endgenerate

  // RAM read port with a fixed latency per instance; garbage when nothing was read.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      rd_pipe[g][0] <= ren_a[g] ? mem[raddr_a[g]] : 32'hDEAD_BEEF;
      for (int k = 1; k < 4; k++) rd_pipe[g][k] <= rd_pipe[g][k-1];
    end
  end

  // Observe handshakes, stalls, read addresses and done pulses away from the clock edge.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int g = 0; g < NI; g++) begin
        if (dout_valid_a[g] && dout_ready && got_n[g] < MAXW) begin
          got[g][got_n[g]] = dout_a[g];
          got_n[g]++;
        end
        if (prev_stall[g] && (!dout_valid_a[g] || dout_a[g] !== prev_dout[g])) stall_err[g]++;
        prev_stall[g] = dout_valid_a[g] && !dout_ready;
        prev_dout[g]  = dout_a[g];
        if (ren_a[g]) begin
          if (raddr_a[g] !== 16'(ren_n[g])) addr_err[g]++;
          last_raddr[g] = raddr_a[g];
          ren_n[g]++;
        end
        if (done_a[g]) done_n[g]++;
      end
    end
  end

  // Reference stream: header, the first min(n, 65536) RAM words, trailer.
  task automatic build_expected(input logic [31:0] n, input logic [1:0] s);
    exp_ovf = (n > 32'd65536);
    exp_cnt = exp_ovf ? 65536 : int'(n);
    exp_q.delete();
    exp_q.push_back(32'hA000_0000 + (exp_ovf ? 32'h0400_0000 : 32'h0) +
                    (32'(s) << 24) + 32'(exp_cnt));
    for (int k = 0; k < exp_cnt; k++) exp_q.push_back(mem[k]);
    exp_q.push_back(32'hE000_0000 + 32'(exp_cnt));
  endtask

  task automatic clear_obs();
    for (int g = 0; g < NI; g++) begin
      got_n[g] = 0; done_n[g] = 0; ren_n[g] = 0; addr_err[g] = 0;
      stall_err[g] = 0; last_raddr[g] = '0; prev_stall[g] = 1'b0; prev_dout[g] = '0;
    end
  endtask

  // Pulse start, then clock until every instance has pulsed done or the budget expires.
  task automatic run_spill(input logic [31:0] n, input logic [1:0] s, input bit rand_rdy,
                           input int extra_at, input int budget, output bit timed_out);
    bit all_done;
    clear_obs();
    mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; ntrig = n; spill = s; dout_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ntrig = $urandom; spill = 2'($urandom_range(0, 3));
    timed_out = 1'b1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      dout_ready = rand_rdy ? ($urandom_range(0, 99) < 30) : 1'b1;
      start = (cyc == extra_at);
      @(posedge clk); #1;
      all_done = 1'b1;
      for (int g = 0; g < NI; g++) if (done_n[g] < 1) all_done = 1'b0;
      if (all_done) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
    dout_ready = 1'b1;
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    rst = 1'b1; start = 1'b0; ntrig = '0; spill = '0; dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      checks++;
      if ({raddr_a[g], ren_a[g], dout_a[g], dout_valid_a[g], busy_a[g], done_a[g],
           start_missed_a[g], ovf_a[g]} !== 54'd0) begin
        failures++;
        $display("[TB] FAIL reset_outputs lat=%0d got=%h exp=0", lat_of(g),
                 {raddr_a[g], ren_a[g], dout_a[g], dout_valid_a[g], busy_a[g], done_a[g],
                  start_missed_a[g], ovf_a[g]});
      end
    end
  endtask

  task automatic test_basic_stream();
    bit to;
    int mism, first;
    mem[0] = 32'h8000_0010; mem[1] = 32'h8000_0020; mem[2] = 32'h8000_0030;
    build_expected(32'd3, 2'd2);
    run_spill(32'd3, 2'd2, 1'b0, -1, 200, to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL basic_timeout got=timeout exp=done"); end
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (got_n[g] != 5) begin
        failures++; $display("[TB] FAIL basic_len lat=%0d got=%0d exp=5", lat_of(g), got_n[g]);
      end
      mism = 0; first = -1;
      for (int k = 0; k < exp_q.size() && k < got_n[g]; k++)
        if (got[g][k] !== exp_q[k]) begin mism++; if (first < 0) first = k; end
      checks++;
      if (mism != 0) begin
        failures++;
        $display("[TB] FAIL basic_stream lat=%0d idx=%0d got=%h exp=%h", lat_of(g), first,
                 got[g][first], exp_q[first]);
      end
      checks++;
      if (got[g][0] !== 32'hA200_0003 || got[g][4] !== 32'hE000_0003) begin
        failures++;
        $display("[TB] FAIL basic_frame lat=%0d got=%h/%h exp=a2000003/e0000003", lat_of(g),
                 got[g][0], got[g][4]);
      end
      checks++;
      if (done_n[g] != 1 || ren_n[g] != 3 || addr_err[g] != 0) begin
        failures++;
        $display("[TB] FAIL basic_reads lat=%0d done=%0d reads=%0d addr_err=%0d exp=1/3/0",
                 lat_of(g), done_n[g], ren_n[g], addr_err[g]);
      end
    end
  endtask

  task automatic test_zero_count();
    bit to;
    logic [1:0] s;
    s = 2'($urandom_range(1, 3));
    build_expected(32'd0, s);
    run_spill(32'd0, s, 1'b0, -1, 100, to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL zero_timeout got=timeout exp=done"); end
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (got_n[g] != 2 || got[g][0] !== exp_q[0] || got[g][1] !== 32'hE000_0000) begin
        failures++;
        $display("[TB] FAIL zero_stream lat=%0d n=%0d got=%h/%h exp=%h/e0000000", lat_of(g),
                 got_n[g], got[g][0], got[g][1], exp_q[0]);
      end
      checks++;
      if (ren_n[g] != 0) begin
        failures++; $display("[TB] FAIL zero_ren lat=%0d got=%0d exp=0", lat_of(g), ren_n[g]);
      end
    end
  endtask

  task automatic test_random_stall();
    bit to;
    int mism, first;
    for (int k = 0; k < 100; k++) mem[k] = $urandom;
    build_expected(32'd100, 2'd1);
    run_spill(32'd100, 2'd1, 1'b1, -1, 3000, to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL stall_timeout got=timeout exp=done"); end
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (got_n[g] != 102) begin
        failures++; $display("[TB] FAIL stall_len lat=%0d got=%0d exp=102", lat_of(g), got_n[g]);
      end
      mism = 0; first = -1;
      for (int k = 0; k < exp_q.size() && k < got_n[g]; k++)
        if (got[g][k] !== exp_q[k]) begin mism++; if (first < 0) first = k; end
      checks++;
      if (mism != 0) begin
        failures++;
        $display("[TB] FAIL stall_stream lat=%0d idx=%0d got=%h exp=%h", lat_of(g), first,
                 got[g][first], exp_q[first]);
      end
      checks++;
      if (stall_err[g] != 0) begin
        failures++;
        $display("[TB] FAIL stall_hold lat=%0d got=%0d exp=0", lat_of(g), stall_err[g]);
      end
    end
  endtask

  task automatic test_overflow();
    bit to;
    int mism, first;
    for (int k = 0; k < 65536; k++) mem[k] = $urandom;
    build_expected(32'd70000, 2'd1);
    run_spill(32'd70000, 2'd1, 1'b0, -1, 70000, to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL ovf_timeout got=timeout exp=done"); end
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (got_n[g] != 65538) begin
        failures++; $display("[TB] FAIL ovf_len lat=%0d got=%0d exp=65538", lat_of(g), got_n[g]);
      end
      mism = 0; first = -1;
      for (int k = 0; k < exp_q.size() && k < got_n[g]; k++)
        if (got[g][k] !== exp_q[k]) begin mism++; if (first < 0) first = k; end
      checks++;
      if (mism != 0) begin
        failures++;
        $display("[TB] FAIL ovf_stream lat=%0d idx=%0d got=%h exp=%h", lat_of(g), first,
                 got[g][first], exp_q[first]);
      end
      checks++;
      if (got[g][0] !== 32'hA501_0000 || got[g][65537] !== 32'hE001_0000) begin
        failures++;
        $display("[TB] FAIL ovf_frame lat=%0d got=%h/%h exp=a5010000/e0010000", lat_of(g),
                 got[g][0], got[g][65537]);
      end
      checks++;
      if (ovf_a[g] !== 1'b1 || ren_n[g] != 65536 || last_raddr[g] !== 16'hFFFF ||
          addr_err[g] != 0) begin
        failures++;
        $display("[TB] FAIL ovf_reads lat=%0d ovf=%0d reads=%0d last=%h addr_err=%0d exp=1/65536/ffff/0",
                 lat_of(g), ovf_a[g], ren_n[g], last_raddr[g], addr_err[g]);
      end
    end
  endtask

  task automatic test_missed_and_reset();
    bit to;
    int mism, first;
    for (int k = 0; k < 50; k++) mem[k] = $urandom;
    build_expected(32'd40, 2'd3);
    run_spill(32'd40, 2'd3, 1'b0, 10, 500, to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL missed_timeout got=timeout exp=done"); end
    for (int g = 0; g < NI; g++) begin
      mism = (got_n[g] != 42) ? 1 : 0; first = 0;
      for (int k = 0; k < exp_q.size() && k < got_n[g]; k++)
        if (got[g][k] !== exp_q[k]) begin if (mism == 0) first = k; mism++; end
      checks++;
      if (mism != 0) begin
        failures++;
        $display("[TB] FAIL missed_stream lat=%0d n=%0d idx=%0d got=%h exp=%h", lat_of(g),
                 got_n[g], first, got[g][first], exp_q[first]);
      end
      checks++;
      if (start_missed_a[g] !== 1'b1 || ovf_a[g] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL missed_flags lat=%0d start_missed=%0d ovf=%0d exp=1/0", lat_of(g),
                 start_missed_a[g], ovf_a[g]);
      end
    end
    mon_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; ntrig = 32'd50; spill = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      checks++;
      if ({raddr_a[g], ren_a[g], dout_a[g], dout_valid_a[g], busy_a[g], done_a[g],
           start_missed_a[g], ovf_a[g]} !== 54'd0) begin
        failures++;
        $display("[TB] FAIL midread_reset lat=%0d got=%h exp=0", lat_of(g),
                 {raddr_a[g], ren_a[g], dout_a[g], dout_valid_a[g], busy_a[g], done_a[g],
                  start_missed_a[g], ovf_a[g]});
      end
    end
    for (int k = 0; k < 5; k++) mem[k] = $urandom;
    build_expected(32'd5, 2'd1);
    run_spill(32'd5, 2'd1, 1'b0, -1, 200, to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL fresh_timeout got=timeout exp=done"); end
    for (int g = 0; g < NI; g++) begin
      mism = (got_n[g] != 7) ? 1 : 0; first = 0;
      for (int k = 0; k < exp_q.size() && k < got_n[g]; k++)
        if (got[g][k] !== exp_q[k]) begin if (mism == 0) first = k; mism++; end
      checks++;
      if (mism != 0 || got[g][0] !== 32'hA100_0005) begin
        failures++;
        $display("[TB] FAIL fresh_stream lat=%0d n=%0d idx=%0d got=%h exp=%h", lat_of(g),
                 got_n[g], first, got[g][first], exp_q[first]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_zero_count();
    test_random_stall();
    test_overflow();
    test_missed_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog got=running exp=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
